// File: rtl/reg_context_engine.sv
// reg_context_engine
//   Save/restore engine for register context. On a start strobe it either
//   streams registers FIRST_REG..LAST_REG from the register-file read port
//   into data memory (save), or fetches bytes from data memory and writes
//   them back through the register-file write port (restore).
//
// Ports
//   clk, rst             single clock, synchronous active-high reset
//   start/mode/base_addr command strobe, direction (0=save, 1=restore),
//                        memory address of FIRST_REG's byte
//   busy, done           busy while not idle; one-cycle completion pulse
//   rf_raddr/rf_rdata    register-file read port (combinational read)
//   rf_we/waddr/wdata    register-file write port
//   mem_req/we/addr/     memory request, held until mem_ready
//   wdata/ready/rdata
module reg_context_engine #(
  parameter int FIRST_REG = 1,
  parameter int LAST_REG  = 31,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic [4:0]        rf_raddr,
  input  logic [7:0]        rf_rdata,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [7:0]        rf_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ready,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [2:0] {IDLE, SAVE, RD_REQ, RD_WR, DONE} state_t;

  localparam logic [4:0]        FIRST_IDX = 5'(FIRST_REG);
  localparam logic [4:0]        LAST_IDX  = 5'(LAST_REG);
  localparam logic [ADDR_W-1:0] FIRST_OFS = ADDR_W'(FIRST_REG);

  state_t            state_reg;
  logic [4:0]        cur_reg;
  logic [ADDR_W-1:0] base_reg;
  logic [7:0]        wdata_reg;
  logic              busy_reg;
  logic              done_reg;

  logic in_save;
  logic in_rd_req;
  logic in_rd_wr;

  // busy/done are tracked alongside the state transitions so they come
  // straight from flops; busy_reg mirrors (state_reg != IDLE).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cur_reg   <= FIRST_IDX;
      base_reg  <= '0;
      wdata_reg <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            base_reg  <= base_addr;
            cur_reg   <= FIRST_IDX;
            busy_reg  <= 1'b1;
            state_reg <= mode ? RD_REQ : SAVE;
          end
        end
        SAVE: begin
          if (mem_ready) begin
            if (cur_reg == LAST_IDX) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else begin
              cur_reg <= cur_reg + 5'd1;
            end
          end
        end
        RD_REQ: begin
          if (mem_ready) begin
            wdata_reg <= mem_rdata;
            state_reg <= RD_WR;
          end
        end
        RD_WR: begin
          if (cur_reg == LAST_IDX) begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end else begin
            cur_reg   <= cur_reg + 5'd1;
            state_reg <= RD_REQ;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign in_save   = (state_reg == SAVE);
  assign in_rd_req = (state_reg == RD_REQ);
  assign in_rd_wr  = (state_reg == RD_WR);

  assign busy = busy_reg;
  assign done = done_reg;

  // Memory side: address wraps naturally in ADDR_W bits. Everything is
  // gated to zero while no request is outstanding.
  assign mem_req   = in_save | in_rd_req;
  assign mem_we    = in_save;
  assign mem_addr  = mem_req ? (base_reg + (ADDR_W'(cur_reg) - FIRST_OFS)) : '0;
  assign mem_wdata = in_save ? rf_rdata : 8'h00;

  // Register-file side: register 0 is hard-wired, so a write to it is
  // suppressed even if the parameters would allow it.
  assign rf_raddr = in_save  ? cur_reg : 5'd0;
  assign rf_we    = in_rd_wr && (cur_reg != 5'd0);
  assign rf_waddr = in_rd_wr ? cur_reg : 5'd0;
  assign rf_wdata = in_rd_wr ? wdata_reg : 8'h00;

endmodule
